fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the control decoder. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. It holds the current instruction in an instruction register whose opcode field drives the control unit's `in`, and applies the control outputs `jump`, `branch` and `PCclr` (plus the ALU zero flag) to select the next PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset and on `pc_clr`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high. One clock, synchronous reset, active-high.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word address; stable while `imem_req`=1 until ack.
- `imem_ack` in 1: `imem_rdata` valid. May be asserted in the same cycle as `imem_req`.
- `imem_rdata` in 32: fetched instruction word.
- `stall` in 1: decode not accepting; hold `ir`.
- `jump` in 1: from control, for the instruction in `ir`.
- `branch` in 1: from control. Ignored when `jump`=1, because control drives it to x for j/jal.
- `pc_clr` in 1: from control `PCclr`.
- `zero` in 1: ALU equality result for the beq in `ir`.
- `ir` out 32: instruction register.
- `ir_valid` out 1: `ir` holds a live instruction.
- `opcode` out 6: `ir[31:26]`, wired to control `in`.
- `pc_plus4` out 32: address of `ir` + 4; jal link value.

## Operation
- States: FETCH (request outstanding or about to issue), BUF (one word captured while stalled), DRAIN (discard the in-flight word after a squash or clear).
- An instruction is consumed when `ir_valid`=1 and `stall`=0 at a clock edge. Redirect is evaluated only at consumption.
- Redirect priority, highest first:
  - `pc_clr`: PC ← `RESET_PC`, `ir_valid` ← 0.
  - `jump`: target = {pc_plus4[31:28], ir[25:0], 2'b00}.
  - `branch`&`zero`: target = pc_plus4 + (sext(ir[15:0])<<2).
  - Otherwise sequential: PC+4.
- Arithmetic is 32-bit and wraps modulo 2^32. There is no misalignment check; the low 2 bits are always 0.
- Ack with consumption possible: `ir` ← `imem_rdata`, `ir_valid` ← 1, next request issues the following cycle, or the same cycle if the memory is combinational.
- Ack while `stall`=1: word goes to a 1-entry buffer and the state moves to BUF. No new request is issued while in BUF. The buffer moves to `ir` on the cycle `stall` drops.
- Redirect while a request is outstanding: `imem_addr` is not changed. Go to DRAIN, wait for the ack, drop the data, then request the target.
- `pc_clr` discards the buffer and any in-flight word (via DRAIN), then fetches `RESET_PC`.
- Simultaneous ack and redirect: the redirect wins. The returning word is treated as the sequential successor (see Configuration).

## Timing
- Reset values: pc=`RESET_PC`, `ir`=32'h0 (nop), `ir_valid`=0, `imem_req`=0, state FETCH, buffer empty.
- The first cycle after reset deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Reset asserted mid-wait overrides a same-cycle ack; that word is lost.
- Latency: ack in cycle N → `ir`/`ir_valid` updated at edge N+1.
- Peak throughput: 1 instruction/cycle with zero-wait memory.
- Taken redirect costs 1 bubble with no delay slot (`ir_valid`=0 for one cycle).
- `opcode`/`pc_plus4` are combinational from registered state. Control may see them change only at edges.

## Configuration
- Macro `FETCH_DELAY_SLOT_EN`.
- Defined: MIPS branch delay slot. The sequential instruction after a taken branch or jump is delivered with `ir_valid`=1 exactly once, then the target. A pending-target register holds the target meanwhile. `pc_clr` still squashes.
- Undefined: the sequential successor is squashed, either in flight (DRAIN) or buffered (dropped).

## Structure
- Shared package `mips_pkg`:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J, OP_JAL.
  - NOP word constant.
  - Fetch state enum.
  - `RESET_PC` default.
- One sub-module, `next_pc`: combinational target/priority selection from pc_plus4, `ir`, `jump`, `branch`, `zero`, `pc_clr`.

## Test plan
- Reset release, ack every cycle → `imem_addr` 0x0, 0x4, 0x8; `ir` follows one cycle later; `ir_valid` rises one cycle after the first ack.
- beq at 0x10 with imm 0x0003 and `zero`=1 → next fetch address 0x20. Without the macro, 0x14 never shows `ir_valid`=1. With the macro, 0x14 is valid once, then 0x20.
- `ir`=0x08000100 (j) at 0x200 → fetch address 0x00000400. `branch`=x during this does not affect the result.
- `stall`=1 for 2 cycles with ack arriving in the first → `ir` unchanged, no `imem_req` while BUF is full, buffered word appears in `ir` the cycle after `stall`=0.
- `pc_clr` with a request outstanding (ack 3 cycles later) → returning word discarded, next request at `RESET_PC`, `ir_valid`=0 until that ack.
- `reset` asserted in the same cycle as `imem_ack` → all reset values next cycle, word not captured.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, the NOP word, the fetch state
// encoding and the default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // S_FETCH: request outstanding or about to issue.
  // S_BUF:   one word captured while decode stalled.
  // S_DRAIN: discard the in-flight word after a squash or clear.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_BUF   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory req/ack bus. The fetch unit is the master.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Redirect target and priority selection for the instruction in ir.
// Priority: pc_clr, then jump, then taken beq. branch is ignored whenever
// jump is set because control leaves it undefined for j/jal.
module next_pc
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] ir_low,      // ir[25:0]: jump index, low 16 = branch imm
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic        pc_clr,
  output logic        redirect,    // any non-sequential next PC
  output logic        taken,       // jump or taken branch (not a clear)
  output logic [31:0] target
);

  logic [31:0] br_offset;

  // Prioritised target mux.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    br_offset = {{14{ir_low[15]}}, ir_low[15:0], 2'b00};
    redirect  = 1'b0;
    taken     = 1'b0;
    target    = pc_plus4;
    if (pc_clr) begin
      redirect = 1'b1;
      target   = RESET_PC;
    end else if (jump) begin
      redirect = 1'b1;
      taken    = 1'b1;
      target   = {pc_plus4[31:28], ir_low, 2'b00};
    end else if (branch && zero) begin
      redirect = 1'b1;
      taken    = 1'b1;
      target   = pc_plus4 + br_offset;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack bus,
// holds the current instruction in ir and redirects on jump/branch/clear.
// Build option FETCH_DELAY_SLOT_EN: when defined, the sequential successor
// of a taken jump/branch is delivered once (MIPS delay slot); otherwise it
// is squashed.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                jump,
  input  logic                branch,
  input  logic                pc_clr,
  input  logic                zero,
  output logic [31:0]         ir,
  output logic                ir_valid,
  output logic [5:0]          opcode,
  output logic [31:0]         pc_plus4
);

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT_EN = 1'b1;
`else
  localparam bit DELAY_SLOT_EN = 1'b0;
`endif

  fetch_state_e state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  pc_q, pc_d;          // address being / about to be fetched
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  ir_pc_q, ir_pc_d;    // address of the word in ir
  logic         ir_valid_q, ir_valid_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  tgt_q, tgt_d;        // redirect target parked during a wait
  logic         tgt_pend_q, tgt_pend_d;

  logic         consume, ack_fire, redirect, taken;
  logic [31:0]  target;

  assign consume  = ir_valid_q && !stall;
  assign ack_fire = req_q && imem.imem_ack;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign ir             = ir_q;
  assign ir_valid       = ir_valid_q;
  assign opcode         = ir_q[31:26];
  assign pc_plus4       = ir_pc_q + 32'd4;

  next_pc #(.RESET_PC(RESET_PC)) u_next_pc (
    .pc_plus4 (pc_plus4),
    .ir_low   (ir_q[25:0]),
    .jump     (jump),
    .branch   (branch),
    .zero     (zero),
    .pc_clr   (pc_clr),
    .redirect (redirect),
    .taken    (taken),
    .target   (target)
  );

  // Next-state logic for the fetch FSM and its datapath registers.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    tgt_d      = tgt_q;
    tgt_pend_d = tgt_pend_q;
    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        if (consume) ir_valid_d = 1'b0;
        if (consume && redirect) begin
          if (DELAY_SLOT_EN && taken) begin
            // The word at pc_q is the delay slot: deliver it, then the target.
            if (ack_fire) begin
              ir_d       = imem.imem_rdata;
              ir_pc_d    = pc_q;
              ir_valid_d = 1'b1;
              pc_d       = target;
            end else begin
              tgt_d      = target;
              tgt_pend_d = 1'b1;
            end
          end else if (ack_fire || !req_q) begin
            // Same-cycle ack is the squashed successor; request target next.
            pc_d = target;
          end else begin
            // Address must stay stable until the outstanding ack.
            tgt_d   = target;
            state_d = S_DRAIN;
          end
        end else if (ack_fire) begin
          if (!ir_valid_q || !stall) begin
            ir_d       = imem.imem_rdata;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = tgt_pend_q ? tgt_q : pc_q + 32'd4;
            tgt_pend_d = 1'b0;
          end else begin
            buf_d    = imem.imem_rdata;
            buf_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            req_d    = 1'b0;
            state_d  = S_BUF;
          end
        end
      end
      S_BUF: begin
        if (consume) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          if (redirect) pc_d = target;
          if (!redirect || (DELAY_SLOT_EN && taken)) begin
            ir_d       = buf_q;
            ir_pc_d    = buf_pc_q;
            ir_valid_d = 1'b1;
          end else begin
            ir_valid_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (ack_fire) begin
          pc_d    = tgt_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q    <= S_FETCH;
      req_q      <= 1'b0;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_WORD;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
      buf_q      <= NOP_WORD;
      buf_pc_q   <= RESET_PC;
      tgt_q      <= RESET_PC;
      tgt_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      tgt_q      <= tgt_d;
      tgt_pend_q <= tgt_pend_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory words are generated from the
// address; a few addresses hold a beq and two jumps.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jump, branch, pc_clr, zero;
  logic [31:0] ir, pc_plus4;
  logic        ir_valid;
  logic [5:0]  opcode;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .imem     (bus),
    .stall    (stall),
    .jump     (jump),
    .branch   (branch),
    .pc_clr   (pc_clr),
    .zero     (zero),
    .ir       (ir),
    .ir_valid (ir_valid),
    .opcode   (opcode),
    .pc_plus4 (pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h1000_0003;  // beq imm=3
      32'h0000_0024: return 32'h0800_0080;  // j 0x200
      32'h0000_0200: return 32'h0800_0100;  // j 0x400
      default:       return 32'hC000_0000 | a;
    endcase
  endfunction

  // Drive one cycle of inputs, advance past the edge, settle.
  task automatic cyc(input logic ack, input logic stl, input logic jmp,
                     input logic br, input logic zr, input logic clr);
    bus.imem_ack   = ack;
    bus.imem_rdata = word_at(bus.imem_addr);
    stall = stl; jump = jmp; branch = br; zero = zr; pc_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (ir !== 32'h0) begin n_bad++; $display("FAIL rst_ir: got %h want 00000000", ir); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", ir_valid); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL rst_pc_plus4: got %h want 00000004", pc_plus4); end
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL seq_first_req: got req=%b addr=%h want req=1 addr=00000000", bus.imem_req, bus.imem_addr); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL seq_no_valid_yet: got %b want 0", ir_valid); end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.imem_addr !== 32'(4 * (i + 1))) begin n_bad++; $display("FAIL seq_addr%0d: got %h want %h", i, bus.imem_addr, 32'(4 * (i + 1))); end
      n_cmp++; if (ir !== word_at(32'(4 * i)) || ir_valid !== 1'b1) begin n_bad++; $display("FAIL seq_ir%0d: got %h/%b want %h/1", i, ir, ir_valid, word_at(32'(4 * i))); end
    end
    n_cmp++; if (opcode !== 6'h04 || pc_plus4 !== 32'h14) begin n_bad++; $display("FAIL seq_beq_decode: got op=%h pc4=%h want 04 00000014", opcode, pc_plus4); end
  endtask

  task automatic test_branch();
    // beq at 0x10 taken while word 0x14 returns in the same cycle.
    cyc(1, 0, 0, 1, 1, 0);
    n_cmp++; if (bus.imem_addr !== 32'h20) begin n_bad++; $display("FAIL br_target: got %h want 00000020", bus.imem_addr); end
`ifdef FETCH_DELAY_SLOT_EN
    n_cmp++; if (ir !== 32'hC000_0014 || ir_valid !== 1'b1) begin n_bad++; $display("FAIL br_slot: got %h/%b want c0000014/1", ir, ir_valid); end
`else
    n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL br_squash: got valid=%b ir=%h want valid 0", ir_valid, ir); end
`endif
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'hC000_0020 || ir_valid !== 1'b1) begin n_bad++; $display("FAIL br_target_ir: got %h/%b want c0000020/1", ir, ir_valid); end
  endtask

  task automatic test_jump();
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'h0800_0080 || opcode !== 6'h02) begin n_bad++; $display("FAIL j1_ir: got %h op=%h want 08000080 op 02", ir, opcode); end
    cyc(1, 0, 1, 0, 0, 0);
    n_cmp++; if (bus.imem_addr !== 32'h200) begin n_bad++; $display("FAIL j1_target: got %h want 00000200", bus.imem_addr); end
`ifdef FETCH_DELAY_SLOT_EN
    n_cmp++; if (ir !== 32'hC000_0028 || ir_valid !== 1'b1) begin n_bad++; $display("FAIL j1_slot: got %h/%b want c0000028/1", ir, ir_valid); end
`else
    n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL j1_squash: got %b want 0", ir_valid); end
`endif
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'h0800_0100 || pc_plus4 !== 32'h204) begin n_bad++; $display("FAIL j2_ir: got %h pc4=%h want 08000100 00000204", ir, pc_plus4); end
    // Jump with 0x204 outstanding; branch/zero high must not matter.
    cyc(0, 0, 1, 1, 1, 0);
    n_cmp++; if (bus.imem_addr !== 32'h204 || bus.imem_req !== 1'b1 || ir_valid !== 1'b0) begin n_bad++; $display("FAIL j2_hold: got addr=%h req=%b valid=%b want 00000204 1 0", bus.imem_addr, bus.imem_req, ir_valid); end
    cyc(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.imem_addr !== 32'h204) begin n_bad++; $display("FAIL j2_stable: got %h want 00000204", bus.imem_addr); end
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.imem_addr !== 32'h400) begin n_bad++; $display("FAIL j2_target: got %h want 00000400", bus.imem_addr); end
`ifdef FETCH_DELAY_SLOT_EN
    n_cmp++; if (ir !== 32'hC000_0204 || ir_valid !== 1'b1) begin n_bad++; $display("FAIL j2_slot: got %h/%b want c0000204/1", ir, ir_valid); end
`else
    n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL j2_drain_drop: got %b want 0", ir_valid); end
`endif
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'hC000_0400 || ir_valid !== 1'b1) begin n_bad++; $display("FAIL j2_target_ir: got %h/%b want c0000400/1", ir, ir_valid); end
  endtask

  task automatic test_stall();
    cyc(1, 1, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'hC000_0400 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL st_buf1: got ir=%h req=%b want c0000400 0", ir, bus.imem_req); end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'hC000_0400 || ir_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL st_buf2: got ir=%h v=%b req=%b want c0000400 1 0", ir, ir_valid, bus.imem_req); end
    cyc(0, 0, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'hC000_0404 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h408) begin n_bad++; $display("FAIL st_release: got ir=%h req=%b addr=%h want c0000404 1 00000408", ir, bus.imem_req, bus.imem_addr); end
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'hC000_0408 || bus.imem_addr !== 32'h40C) begin n_bad++; $display("FAIL st_resume: got ir=%h addr=%h want c0000408 0000040c", ir, bus.imem_addr); end
  endtask

  task automatic test_pc_clr();
    cyc(0, 0, 0, 0, 0, 1);
    n_cmp++; if (bus.imem_addr !== 32'h40C || bus.imem_req !== 1'b1 || ir_valid !== 1'b0) begin n_bad++; $display("FAIL clr_hold: got addr=%h req=%b v=%b want 0000040c 1 0", bus.imem_addr, bus.imem_req, ir_valid); end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.imem_addr !== 32'h40C || ir_valid !== 1'b0) begin n_bad++; $display("FAIL clr_wait: got addr=%h v=%b want 0000040c 0", bus.imem_addr, ir_valid); end
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.imem_addr !== 32'h0 || ir_valid !== 1'b0) begin n_bad++; $display("FAIL clr_drop: got addr=%h v=%b want 00000000 0", bus.imem_addr, ir_valid); end
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'hC000_0000 || ir_valid !== 1'b1 || bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL clr_refetch: got ir=%h v=%b addr=%h want c0000000 1 00000004", ir, ir_valid, bus.imem_addr); end
  endtask

  task automatic test_reset_with_ack();
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h0 || pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL rack_values: got req=%b v=%b ir=%h pc4=%h want 0 0 00000000 00000004", bus.imem_req, ir_valid, ir, pc_plus4); end
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || ir_valid !== 1'b0) begin n_bad++; $display("FAIL rack_restart: got req=%b addr=%h v=%b want 1 00000000 0", bus.imem_req, bus.imem_addr, ir_valid); end
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++; if (ir !== 32'hC000_0000 || ir_valid !== 1'b1) begin n_bad++; $display("FAIL rack_first: got %h/%b want c0000000/1", ir, ir_valid); end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; jump = 1'b0; branch = 1'b0; pc_clr = 1'b0; zero = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_pc_clr();
    test_reset_with_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
